// File: rtl/add_serial_pkg.sv
// add_serial_pkg
//   Shared definitions for the digit-serial adder/subtractor.
//   - state_t    : FSM state encoding (IDLE, ADD, DONE)
//   - cnt_width(): width of the digit counter for a WIDTH/DIGIT pair
package add_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must reach NDIG-1; a single digit still needs one bit.
    function automatic int cnt_width(input int width, input int digit);
        int ndig;
        ndig = width / digit;
        return ($clog2(ndig) < 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// serial_digit_adder
//   Combinational DIGIT-wide ripple adder used once per cycle by the
//   serial datapath.
//   Ports:
//     a_d, b_d  in  DIGIT  operand digits
//     cin       in  1      carry into the digit LSB
//     s         out DIGIT  digit sum
//     cout      out 1      carry out of the digit MSB
//     c_msb_in  out 1      carry into the digit MSB (signed overflow detect)
module serial_digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    // c[i] is the carry into bit i; c[DIGIT] leaves the digit.
    logic [DIGIT:0] c;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < DIGIT; i++) begin : g_bit
            assign s[i]   = a_d[i] ^ b_d[i] ^ c[i];
            assign c[i+1] = (a_d[i] & b_d[i]) | (a_d[i] & c[i]) | (b_d[i] & c[i]);
        end
    endgenerate

    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/add_serial_param.sv
// add_serial_param
//   Digit-serial adder/subtractor. Consumes DIGIT bits per cycle, LSB
//   first, and finishes a WIDTH-bit operation in WIDTH/DIGIT cycles.
//   Subtraction is a + ~b + ~cin, so the same adder serves both modes and
//   carry-out is inverted to report a borrow.
//   Ports:
//     clk, rst        clock (rising edge), synchronous active-high reset
//     start           request; taken only while ready=1
//     sub, cin, a, b  operation and operands, sampled on accept
//     ready           IDLE or DONE
//     busy            ADD
//     done            DONE, result valid and held
//     out, cout, ovf  result, carry/borrow out, signed overflow
module add_serial_param
    import add_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0 || (WIDTH / DIGIT) < 2) begin : g_bad_param
            $error("add_serial_param: DIGIT must divide WIDTH with WIDTH/DIGIT >= 2");
        end
    endgenerate

    state_t          state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic            carry;
    logic            sub_reg;
    logic [CW-1:0]   count;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             dig_cmsb;

    serial_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d      (a_reg[DIGIT-1:0]),
        .b_d      (b_reg[DIGIT-1:0]),
        .cin      (carry),
        .s        (dig_s),
        .cout     (dig_cout),
        .c_msb_in (dig_cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            carry   <= 1'b0;
            sub_reg <= 1'b0;
            count   <= '0;
            out     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                // DONE shares the load path so a restart skips IDLE.
                IDLE, DONE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= sub ? ~b : b;
                        carry   <= sub ? ~cin : cin;
                        sub_reg <= sub;
                        count   <= '0;
                        out     <= '0;
                        state   <= ADD;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                ADD: begin
                    // New digit enters at the top; after NDIG shifts the
                    // first digit has reached the LSBs.
                    out   <= {dig_s, out[WIDTH-1:DIGIT]};
                    a_reg <= a_reg >> DIGIT;
                    b_reg <= b_reg >> DIGIT;
                    carry <= dig_cout;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        cout  <= sub_reg ? ~dig_cout : dig_cout;
                        ovf   <= dig_cmsb ^ dig_cout;
                        state <= DONE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_serial_param.sv
// Testbench for add_serial_param: one 8-bit/1-digit and one 16-bit/4-digit
// instance, checked every cycle against an arithmetic reference model.
module tb_add_serial_param;

    logic clk;
    logic rst;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       rdy8, busy8, done8, cout8, ovf8;
    logic [7:0] out8;

    logic        start16, sub16, cin16;
    logic [15:0] a16, b16;
    logic        rdy16, busy16, done16, cout16, ovf16;
    logic [15:0] out16;

    int n_cmp = 0;
    int n_bad = 0;

    add_serial_param #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8),
        .a(a8), .b(b8), .ready(rdy8), .busy(busy8), .done(done8),
        .out(out8), .cout(cout8), .ovf(ovf8)
    );

    add_serial_param #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .cin(cin16),
        .a(a16), .b(b16), .ready(rdy16), .busy(busy16), .done(done16),
        .out(out16), .cout(cout16), .ovf(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_w[2]  = '{8, 16};
    int          m_nd[2] = '{8, 4};
    bit          m_ready[2], m_busy[2], m_done[2], m_idle[2];
    int          m_left[2];
    logic [15:0] m_out[2], p_out[2];
    bit          m_cout[2], m_ovf[2], p_cout[2], p_ovf[2];

    // Plain integer arithmetic for the result of one operation.
    task automatic calc(input int w, input logic [15:0] a, input logic [15:0] b,
                        input bit s, input bit c,
                        output logic [15:0] o, output bit co, output bit ov);
        longint mask, ua, ub, sa, sb, r, sr, lim;
        mask = (64'sd1 <<< w) - 1;
        lim  = 64'sd1 <<< (w - 1);
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua >= lim) ? ua - (64'sd1 <<< w) : ua;
        sb = (ub >= lim) ? ub - (64'sd1 <<< w) : ub;
        if (!s) begin
            r  = ua + ub + longint'(c);
            co = (r >>> w) != 0;
            sr = sa + sb + longint'(c);
        end else begin
            r  = ua - ub - longint'(c);
            co = ua < ub + longint'(c);
            sr = sa - sb - longint'(c);
        end
        o  = 16'(r & mask);
        ov = (sr >= lim) || (sr < -lim);
    endtask

    task automatic model_step(input int d, input bit st, input bit s, input bit c,
                              input logic [15:0] a, input logic [15:0] b);
        if (rst) begin
            m_ready[d] = 1; m_busy[d] = 0; m_done[d] = 0; m_idle[d] = 1;
            m_left[d] = 0; m_out[d] = '0; m_cout[d] = 0; m_ovf[d] = 0;
        end else if (m_ready[d] && st) begin
            calc(m_w[d], a, b, s, c, p_out[d], p_cout[d], p_ovf[d]);
            m_left[d] = m_nd[d];
            m_ready[d] = 0; m_busy[d] = 1; m_done[d] = 0; m_idle[d] = 0;
        end else if (m_busy[d]) begin
            m_left[d]--;
            if (m_left[d] == 0) begin
                m_busy[d] = 0; m_done[d] = 1; m_ready[d] = 1;
                m_out[d] = p_out[d]; m_cout[d] = p_cout[d]; m_ovf[d] = p_ovf[d];
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, start8, sub8, cin8, {8'h00, a8}, {8'h00, b8});
        model_step(1, start16, sub16, cin16, a16, b16);
    end

    // ---------------- compare process ----------------
    task automatic cmp_dut(input int d, input logic r, input logic bz, input logic dn,
                           input logic [15:0] o, input logic co, input logic ov);
        chk($sformatf("dut%0d ready", d), {31'd0, r},  {31'd0, m_ready[d]});
        chk($sformatf("dut%0d busy", d),  {31'd0, bz}, {31'd0, m_busy[d]});
        chk($sformatf("dut%0d done", d),  {31'd0, dn}, {31'd0, m_done[d]});
        if (m_done[d] || m_idle[d]) begin
            chk($sformatf("dut%0d out", d),  {16'd0, o},   {16'd0, m_out[d]});
            chk($sformatf("dut%0d cout", d), {31'd0, co},  {31'd0, m_cout[d]});
            chk($sformatf("dut%0d ovf", d),  {31'd0, ov},  {31'd0, m_ovf[d]});
        end
    endtask

    always @(negedge clk) begin
        cmp_dut(0, rdy8, busy8, done8, {8'h00, out8}, cout8, ovf8);
        cmp_dut(1, rdy16, busy16, done16, out16, cout16, ovf16);
    end

    // ---------------- stimulus ----------------
    // Called at a negedge with the target ready; returns busy cycle count.
    task automatic op(input int d, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic c, output int bc);
        bit fin;
        if (d == 0) begin a8 = a[7:0]; b8 = b[7:0]; sub8 = s; cin8 = c; start8 = 1; end
        else        begin a16 = a; b16 = b; sub16 = s; cin16 = c; start16 = 1; end
        bc = 0;
        fin = 0;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(negedge clk);
            start8 = 0; start16 = 0;
            if ((d == 0) ? busy8 : busy16) bc++;
            fin = (d == 0) ? done8 : done16;
        end
        if (!fin) chk("op timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int bc, seen;
        logic [15:0] ra, rb;
        rst = 1; start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
        start16 = 0; sub16 = 0; cin16 = 0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("reset ready", {31'd0, rdy8}, 32'd1);
        chk("reset busy",  {31'd0, busy8}, 32'd0);
        chk("reset done",  {31'd0, done8}, 32'd0);
        chk("reset out",   {24'd0, out8}, 32'd0);

        op(0, 16'h5A, 16'h3C, 0, 0, bc);
        chk("add busy cycles", bc, 32'd8);
        chk("add out",  {24'd0, out8}, 32'h96);
        chk("add cout", {31'd0, cout8}, 32'd0);
        chk("add ovf",  {31'd0, ovf8}, 32'd1);

        op(0, 16'h10, 16'h20, 1, 0, bc);
        chk("sub out",    {24'd0, out8}, 32'hF0);
        chk("sub borrow", {31'd0, cout8}, 32'd1);
        chk("sub ovf",    {31'd0, ovf8}, 32'd0);

        op(0, 16'h7F, 16'h00, 0, 1, bc);
        chk("7f+cin out",  {24'd0, out8}, 32'h80);
        chk("7f+cin ovf",  {31'd0, ovf8}, 32'd1);
        chk("7f+cin cout", {31'd0, cout8}, 32'd0);

        op(0, 16'h00, 16'h00, 1, 1, bc);
        chk("0-0-1 out",  {24'd0, out8}, 32'hFF);
        chk("0-0-1 cout", {31'd0, cout8}, 32'd1);

        op(1, 16'hFFFF, 16'h0001, 0, 0, bc);
        chk("w16 busy cycles", bc, 32'd4);
        chk("w16 out",  {16'd0, out16}, 32'h0000);
        chk("w16 cout", {31'd0, cout16}, 32'd1);
        chk("w16 ovf",  {31'd0, ovf16}, 32'd0);

        // start held high and operands changed during ADD
        a8 = 8'h01; b8 = 8'h02; sub8 = 0; cin8 = 0; start8 = 1;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sub8 = 1; cin8 = 1;
        repeat (4) @(negedge clk);
        start8 = 0;
        seen = 0;
        for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
        chk("held start out", {24'd0, out8}, 32'h03);
        chk("held start done", {31'd0, done8}, 32'd1);

        // restart straight from DONE
        a8 = 8'h03; b8 = 8'h04; sub8 = 0; cin8 = 0; start8 = 1;
        @(negedge clk);
        start8 = 0;
        chk("restart busy",  {31'd0, busy8}, 32'd1);
        chk("restart ready", {31'd0, rdy8}, 32'd0);
        for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
        chk("restart out", {24'd0, out8}, 32'h07);

        // reset mid-operation
        a8 = 8'h55; b8 = 8'h22; start8 = 1;
        @(negedge clk);
        start8 = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort ready", {31'd0, rdy8}, 32'd1);
        chk("abort busy",  {31'd0, busy8}, 32'd0);
        chk("abort done",  {31'd0, done8}, 32'd0);
        chk("abort out",   {24'd0, out8}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) seen++;
        end
        chk("abort no done", seen, 32'd0);

        // randomized operations, checked by the model every cycle
        for (int n = 0; n < 160; n++) begin
            int d;
            d  = int'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (n % 7 == 0) rb = 16'hFFFF;
            if (n % 11 == 0) ra = 16'h0000;
            op(d, ra, rb, 1'($urandom), 1'($urandom), bc);
            chk("rand busy cycles", bc, (d == 0) ? 32'd8 : 32'd4);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
